// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch address, captures the EPC and keeps a
// return-address stack used only to check jr-return targets.
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0180),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              branch_ne,
  input  logic              zero_flag,
  input  logic              jump_en,
  input  logic              jr_en,
  input  logic              link_en,
  input  logic              ret_en,
  input  logic              exc_req,
  input  logic [15:0]       field_addr16,
  input  logic [25:0]       field_addr26,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc_out,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_mispredict
);

  localparam int unsigned       PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned       CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] SEG_MASK = ADDR_W'(32'h0FFF_FFFF);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  if (ADDR_W < 28) begin : g_addr_w_check
    $error("pc_sequencer: ADDR_W must be >= 28");
  end
  if (RAS_DEPTH < 2) begin : g_ras_depth_check
    $error("pc_sequencer: RAS_DEPTH must be >= 2");
  end

  logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
  logic [ADDR_W-1:0] jump_tgt, jr_tgt, br_off, br_tgt;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]  top_q, top_d, top_inc, top_dec;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, mis_q, mis_d;
  logic              br_taken, do_push, do_pop;

  // Candidate targets
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign jump_tgt = (pc_plus4 & ~SEG_MASK) | ADDR_W'({field_addr26, 2'b00});
  assign jr_tgt   = jr_target & WORD_MASK;
  assign br_off   = {{(ADDR_W-18){field_addr16[15]}}, field_addr16, 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign br_taken = branch_en & (zero_flag ^ branch_ne);

  // Circular stack pointer neighbours; full stack pushes overwrite the oldest slot
  assign top_inc = (top_q == PTR_MAX) ? '0 : top_q + PTR_W'(1);
  assign top_dec = (top_q == '0) ? PTR_MAX : top_q - PTR_W'(1);

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);
  assign mis_d     = do_pop & (ras_empty | (ras_q[top_q] != jr_tgt));

  // Next-PC selection and which stack operations the selected control requests
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (exc_req) begin
      pc_d  = EXC_VEC;
      epc_d = pc_q;
    end else if (!stall) begin
      if (jump_en) begin
        pc_d    = jump_tgt;
        do_push = link_en;
      end else if (jr_en) begin
        pc_d    = jr_tgt;
        do_push = link_en;
        do_pop  = ret_en;
      end else if (br_taken) begin
        pc_d = br_tgt;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // Return-address stack update; pop+push on a non-empty stack replaces the top in place
  always_comb begin
    ras_d = ras_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (do_pop && !ras_empty && do_push) begin
      ras_d[top_q] = pc_plus4;
    end else if (do_pop && !ras_empty) begin
      top_d = top_dec;
      cnt_d = cnt_q - CNT_W'(1);
    end else if (do_push) begin
      ras_d[top_inc] = pc_plus4;
      top_d          = top_inc;
      if (ras_full) ovf_d = 1'b1;
      else          cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
      ras_q <= '{default: '0};
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      ras_q <= ras_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      mis_q <= mis_d;
    end
  end

  assign pc_out         = pc_q;
  assign epc_out        = epc_q;
  assign ras_overflow   = ovf_q;
  assign ras_mispredict = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model checked every cycle, plus literal
// expectations for the directed scenarios.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch_en, branch_ne, zero_flag;
  logic        jump_en, jr_en, link_en, ret_en, exc_req;
  logic [15:0] field_addr16;
  logic [25:0] field_addr26;
  logic [31:0] jr_target;
  logic [31:0] pc_out, pc_plus4, epc_out;
  logic        ras_empty, ras_full, ras_overflow, ras_mispredict;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_ne(branch_ne), .zero_flag(zero_flag), .jump_en(jump_en),
    .jr_en(jr_en), .link_en(link_en), .ret_en(ret_en), .exc_req(exc_req),
    .field_addr16(field_addr16), .field_addr26(field_addr26),
    .jr_target(jr_target), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .epc_out(epc_out), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_mispredict(ras_mispredict)
  );

  always #5 clk = ~clk;

  // Reference model: the stack is a plain queue, newest entry at the back
  logic [31:0] m_pc, m_epc, m_p4, m_tgt, m_top;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_mis;

  task automatic m_push(input logic [31:0] v);
    m_ras.push_back(v);
    if (m_ras.size() > 4) begin
      void'(m_ras.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_ras.delete(); m_ovf = 1'b0; m_mis = 1'b0;
    end else if (exc_req) begin
      m_epc = m_pc; m_pc = 32'h180; m_mis = 1'b0;
    end else if (stall) begin
      m_mis = 1'b0;
    end else begin
      m_p4  = m_pc + 32'd4;
      m_mis = 1'b0;
      if (jump_en) begin
        m_tgt = {m_p4[31:28], 28'(field_addr26) * 28'd4};
        if (link_en) m_push(m_p4);
      end else if (jr_en) begin
        m_tgt = {jr_target[31:2], 2'b00};
        if (ret_en) begin
          if (m_ras.size() == 0) m_mis = 1'b1;
          else begin
            m_top = m_ras.pop_back();
            m_mis = (m_top != m_tgt);
          end
        end
        if (link_en) m_push(m_p4);
      end else if (branch_en && (zero_flag != branch_ne)) begin
        m_tgt = m_p4 + 32'($signed(field_addr16)) * 32'd4;
      end else begin
        m_tgt = m_p4;
      end
      m_pc = m_tgt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model pc_out", pc_out, m_pc);
    chk("model pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("model epc_out", epc_out, m_epc);
    chk("model ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("model ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
    chk("model ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    chk("model ras_mispredict", 32'(ras_mispredict), 32'(m_mis));
  endtask

  task automatic idle();
    reset = 0; stall = 0; branch_en = 0; branch_ne = 0; zero_flag = 0;
    jump_en = 0; jr_en = 0; link_en = 0; ret_en = 0; exc_req = 0;
    field_addr16 = '0; field_addr26 = '0; jr_target = '0;
  endtask

  // Advance one cycle, compare against the model, then return inputs to idle
  task automatic tick();
    @(posedge clk);
    #1;
    cmp_model();
    idle();
  endtask

  task automatic do_jump(input logic [25:0] a, input logic link);
    jump_en = 1; field_addr26 = a; link_en = link; tick();
  endtask

  task automatic do_jr(input logic [31:0] t, input logic link, input logic ret);
    jr_en = 1; jr_target = t; link_en = link; ret_en = ret; tick();
  endtask

  task automatic do_branch(input logic ne, input logic z, input logic [15:0] imm);
    branch_en = 1; branch_ne = ne; zero_flag = z; field_addr16 = imm; tick();
  endtask

  logic [31:0] lifo [4];

  initial begin
    idle();
    reset = 1; tick();
    reset = 1; tick();
    chk("reset pc", pc_out, 32'h0);
    chk("reset empty", 32'(ras_empty), 32'h1);
    chk("reset epc", epc_out, 32'h0);
    chk("reset mispredict", 32'(ras_mispredict), 32'h0);
    tick(); chk("seq pc 4", pc_out, 32'h4);
    tick(); tick(); chk("seq pc 12", pc_out, 32'hC);
    do_jump(26'h4, 1); chk("jal to 0x10", pc_out, 32'h10);
    reset = 1; stall = 1; tick();
    chk("mid-run reset pc", pc_out, 32'h0);
    chk("mid-run reset empty", 32'(ras_empty), 32'h1);

    // Conditional branches from 0x100
    do_jump(26'h40, 0); do_branch(0, 1, 16'hFFFE); chk("beq taken", pc_out, 32'hFC);
    do_jump(26'h40, 0); do_branch(0, 0, 16'hFFFE); chk("beq not taken", pc_out, 32'h104);
    do_jump(26'h40, 0); do_branch(1, 0, 16'hFFFE); chk("bne taken", pc_out, 32'hFC);

    // Call / return checking
    do_jr(32'h1000_0040, 0, 0);
    do_jump(26'h100, 1); chk("jal seg target", pc_out, 32'h1000_0400);
    do_jr(32'h1000_0044, 0, 1);
    chk("ret match pc", pc_out, 32'h1000_0044);
    chk("ret match no mispredict", 32'(ras_mispredict), 32'h0);
    do_jr(32'h1000_0040, 0, 0);
    do_jump(26'h100, 1);
    do_jr(32'h1000_0048, 0, 1);
    chk("ret mismatch pulse", 32'(ras_mispredict), 32'h1);
    tick(); chk("mispredict one cycle", 32'(ras_mispredict), 32'h0);

    // Overflow and LIFO order
    reset = 1; tick();
    for (int i = 1; i <= 5; i++) do_jump(26'(i * 'h40), 1);
    chk("five pushes full", 32'(ras_full), 32'h1);
    chk("five pushes overflow", 32'(ras_overflow), 32'h1);
    lifo[0] = 32'h404; lifo[1] = 32'h304; lifo[2] = 32'h204; lifo[3] = 32'h104;
    for (int i = 0; i < 4; i++) begin
      do_jr(lifo[i], 0, 1);
      chk("lifo pop match", 32'(ras_mispredict), 32'h0);
    end
    chk("drained empty", 32'(ras_empty), 32'h1);
    do_jr(32'h0, 0, 1);
    chk("empty pop mispredict", 32'(ras_mispredict), 32'h1);
    chk("overflow sticky", 32'(ras_overflow), 32'h1);

    // Stall holds everything; exception overrides stall
    do_jump(26'h80, 0);
    for (int i = 0; i < 3; i++) begin
      stall = 1; jump_en = 1; link_en = 1; field_addr26 = 26'h300; tick();
      chk("stall hold pc", pc_out, 32'h200);
      chk("stall hold ras", 32'(ras_empty), 32'h1);
    end
    stall = 1; exc_req = 1; tick();
    chk("exc pc", pc_out, 32'h180);
    chk("exc epc", epc_out, 32'h200);

    // Wrap-around and priority corners
    do_jr(32'hFFFF_FFFF, 0, 0); chk("jr low bits cleared", pc_out, 32'hFFFF_FFFC);
    tick(); chk("pc wraps to 0", pc_out, 32'h0);
    jump_en = 1; field_addr26 = 26'h10; branch_en = 1; zero_flag = 1; field_addr16 = 16'h1;
    tick(); chk("jump beats branch", pc_out, 32'h40);
    jump_en = 1; field_addr26 = 26'h20; jr_en = 1; ret_en = 1; jr_target = 32'h500;
    tick();
    chk("jump beats jr", pc_out, 32'h80);
    chk("ret ignored under jump", 32'(ras_mispredict), 32'h0);
    link_en = 1; tick(); chk("lone link ignored", 32'(ras_empty), 32'h1);
    do_jump(26'h40, 1);
    do_jr(32'h88, 1, 1);
    chk("jalr+ret match", 32'(ras_mispredict), 32'h0);
    chk("jalr+ret count kept", 32'(ras_empty), 32'h0);
    do_jr(32'h104, 0, 1);
    chk("jalr+ret replaced top", 32'(ras_mispredict), 32'h0);
    do_branch(0, 1, 16'h8000); chk("branch negative wrap", pc_out, 32'hFFFE_0108);
    exc_req = 1; stall = 1; reset = 1; tick();
    chk("reset beats exc", pc_out, 32'h0);
    chk("reset clears epc", epc_out, 32'h0);
    chk("reset clears overflow", 32'(ras_overflow), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the MIPS core. It produces the fetch address each cycle and selects among sequential, branch, jump, jump-register, exception and stall cases. It adds a return-address stack (RAS) that tracks jal/jalr calls and flags return-address mismatches on jr, plus an EPC capture register. It sits between the control unit/ALU zero flag and instruction memory, replacing the fixed 32-bit counter.

Parameters:
ADDR_W, 32, PC width in bits. Must be >= 28; elaboration fails otherwise.
RESET_VEC, 32'h0000_0000, pc_out value after reset.
EXC_VEC, 32'h0000_0180, pc_out value loaded on an exception.
RAS_DEPTH, 4, number of return-stack entries (>= 2).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; clears all state
stall  in  1  hold PC and RAS this cycle
branch_en  in  1  conditional branch instruction
branch_ne  in  1  0 = beq (taken when zero_flag=1); 1 = bne (taken when zero_flag=0)
zero_flag  in  1  ALU zero result
jump_en  in  1  j/jal
jr_en  in  1  jr/jalr
link_en  in  1  with jump_en or jr_en, push the return address (jal/jalr)
ret_en  in  1  with jr_en, pop the RAS and check it (jr $ra)
exc_req  in  1  exception request
field_addr16  in  16  branch immediate
field_addr26  in  26  jump index
jr_target  in  ADDR_W  register jump target
pc_out  out  ADDR_W  registered fetch address
pc_plus4  out  ADDR_W  pc_out + 4, combinational
epc_out  out  ADDR_W  PC of the excepting instruction
ras_empty  out  1  RAS holds 0 entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_overflow  out  1  sticky: a push occurred while full
ras_mispredict  out  1  registered one-cycle pulse

Behaviour:
- All state updates occur on the rising clk edge. A control change is visible on pc_out the following cycle.
- Reset state: pc_out=RESET_VEC, epc_out=0, RAS count=0, ras_empty=1, ras_full=0, ras_overflow=0, ras_mispredict=0. Reset wins over every other input, including mid-stall and mid-exception.
- Next-PC priority (highest first): reset > exc_req > stall > jump_en > jr_en > taken branch > pc_plus4.
- exc_req: pc_out<=EXC_VEC, epc_out<=pc_out. No RAS change. Overrides stall.
- stall (no exc_req): pc_out, RAS and epc hold. link_en/ret_en are ignored. ras_mispredict<=0.
- jump target: {pc_plus4[ADDR_W-1:28], field_addr26, 2'b00}.
- jr target: jr_target, with bits [1:0] forced to 0.
- branch taken: branch_en & (zero_flag ^ branch_ne). Target = pc_plus4 + (sign_extend(field_addr16) << 2), modulo 2^ADDR_W with wrap-around.
- All sums truncate to ADDR_W. pc_plus4 wraps from all-ones-minus-3 to 0.
- Simultaneous jump_en and jr_en: jump_en wins, and link/ret are evaluated against jump_en only. ret_en is ignored when jr_en is not selected.
- link_en without jump_en or jr_en: ignored.
- RAS push (selected jump with link_en): pushes pc_plus4 (the return address).
  - Not full: count++.
  - Full: the oldest entry is overwritten (circular), count stays RAS_DEPTH, ras_overflow<=1.
- RAS pop (jr_en selected, ret_en=1, link_en=0):
  - Non-empty: count--, compare top with the jr target. On mismatch, ras_mispredict<=1 next cycle.
  - Empty: no pop, ras_mispredict<=1.
  - The PC always takes the jr target. The RAS is a checker, not a predictor.
- jalr with ret_en (link_en=1, ret_en=1): pop then push in the same cycle. Net count is unchanged, the top is replaced by pc_plus4, and the popped top is still compared.
- ras_mispredict is 0 in every cycle not caused by a pop check.
- ras_empty and ras_full are decoded combinationally from the registered count.

Test Plan:
- Reset=1 for 2 cycles, then release with no controls -> pc_out 0,4,8,12. Assert reset mid-run at pc=0x10 -> next pc_out=0 and RAS empty.
- pc=0x100, branch_en=1, branch_ne=0, zero_flag=1, imm16=0xFFFE -> pc_out=0xFC. Same with zero_flag=0 -> 0x104. With branch_ne=1 and zero_flag=0 -> 0xFC.
- pc=0x1000_0040, jump_en=1, link_en=1, addr26=0x0000100 -> pc_out=0x1000_0400, RAS top=0x1000_0044. Then jr_en=1, ret_en=1, jr_target=0x1000_0044 -> pc_out=0x1000_0044, mispredict stays 0. Repeat with jr_target=0x1000_0048 -> mispredict pulses once.
- Five jal pushes with RAS_DEPTH=4 -> ras_full=1 and ras_overflow=1. Four pops return the last four addresses in LIFO order. A fifth pop -> ras_empty=1 and mispredict pulse.
- stall=1 for 3 cycles while jump_en=1 -> pc_out holds and RAS is unchanged. Assert exc_req during stall at pc=0x200 -> pc_out=0x180, epc_out=0x200.
- pc=0xFFFF_FFFC, no control -> pc_out=0x0 (wrap-around). jump_en and branch taken together -> jump target wins.
